// File: rtl/spi_pkg.sv
// spi_pkg: SPI mode encoding, default word width, word-index width and frame states
package spi_pkg;
  localparam int DATA_W_DEF = 24;
  localparam int IDX_W = 8;
  typedef enum logic [1:0] {MODE0, MODE1, MODE2, MODE3} spi_mode_e;
  typedef enum logic [1:0] {ST_WAIT, ST_IDLE, ST_ACTIVE} frame_state_e;
  function automatic logic sample_on_rise(input logic [1:0] mode);
    return mode[1] == mode[0];
  endfunction
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: SYNC_STAGES-deep synchronizer with rise/fall detection on its output
module spi_edge_sync #(
  parameter int SYNC_STAGES = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  assign level = sync_q[SYNC_STAGES-1];
  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;
endmodule

// File: rtl/spi_word_receiver.sv
// spi_word_receiver: oversampled SPI slave collecting DATA_W-bit words per CS frame;
// the MISO transmit path is built only with SPI_WORD_RECEIVER_MISO_EN defined.
module spi_word_receiver
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter logic CPOL = 1'b0,
  parameter logic CPHA = 1'b0,
  parameter int SYNC_STAGES = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_clk,
  input  logic              i_spi_cs,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_tx_load,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic [IDX_W-1:0]  o_rx_word_idx,
  output logic              o_frame_end,
  output logic              o_err_short
);
  localparam spi_mode_e MODE = spi_mode_e'({CPOL, CPHA});
  localparam logic SAMPLE_RISE = sample_on_rise(MODE);
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);
  localparam logic [IDX_W-1:0] IDX_MAX = '1;
  logic unused_sck_level, sck_rise, sck_fall, cs_level, cs_rise, cs_fall, mosi;
  logic [SYNC_STAGES-1:0] mosi_q;
  frame_state_e state_q, state_d;
  logic [2:0] settle_q;
  logic start, stop, sample, word_done;
  logic [DATA_W-1:0] shreg_q;
  logic [BW-1:0] bit_q;
  logic [IDX_W-1:0] word_q;
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sck (
    .clk(i_clk), .rst_n(i_rst_n), .din(i_spi_clk),
    .level(unused_sck_level), .rise(sck_rise), .fall(sck_fall)
  );
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(i_clk), .rst_n(i_rst_n), .din(i_spi_cs),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) mosi_q <= '0;
    else mosi_q <= {mosi_q[SYNC_STAGES-2:0], i_spi_mosi};
  assign mosi = mosi_q[SYNC_STAGES-1];
  // After reset the CS synchronizer must flush and show CS high before a frame may start,
  // so a frame interrupted by reset is dropped silently.
  always_comb begin
    start = state_q == ST_IDLE && cs_fall;
    stop = state_q == ST_ACTIVE && cs_rise;
    sample = state_q == ST_ACTIVE && (SAMPLE_RISE ? sck_rise : sck_fall);
    word_done = sample && bit_q == BIT_LAST;
    state_d = state_q == ST_WAIT ? ((settle_q == SETTLE && cs_level) ? ST_IDLE : ST_WAIT)
            : start ? ST_ACTIVE : stop ? ST_IDLE : state_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= ST_WAIT;
      settle_q <= '0;
    end else begin
      state_q <= state_d;
      settle_q <= settle_q == SETTLE ? settle_q : settle_q + 3'd1;
    end
  // A sample edge seen with the CS rise is processed first, so a completed word wins over the error.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      shreg_q <= '0;
      bit_q <= '0;
      word_q <= '0;
      o_rx_data <= '0;
      o_rx_word_idx <= '0;
      o_rx_valid <= 1'b0;
      o_frame_end <= 1'b0;
      o_err_short <= 1'b0;
    end else begin
      o_rx_valid <= word_done;
      o_frame_end <= stop;
      o_err_short <= stop && !word_done && (sample || bit_q != '0);
      if (start || stop) begin
        shreg_q <= '0;
        bit_q <= '0;
        word_q <= '0;
      end else if (sample) begin
        shreg_q <= {shreg_q[DATA_W-2:0], mosi};
        bit_q <= word_done ? '0 : bit_q + 1'b1;
        word_q <= (word_done && word_q != IDX_MAX) ? word_q + 1'b1 : word_q;
      end
      if (word_done) begin
        o_rx_data <= {shreg_q[DATA_W-2:0], mosi};
        o_rx_word_idx <= word_q;
      end
    end
`ifdef SPI_WORD_RECEIVER_MISO_EN
  logic shift;
  logic [DATA_W-1:0] tx_q;
  assign shift = state_q == ST_ACTIVE && (SAMPLE_RISE ? sck_fall : sck_rise);
  // With CPHA=0 the MSB must be on the line before the first sample edge, so it leaves at CS fall.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      tx_q <= '0;
      o_spi_miso <= 1'b0;
      o_tx_load <= 1'b0;
    end else begin
      o_tx_load <= start || word_done;
      if (start) begin
        tx_q <= CPHA ? i_tx_data : i_tx_data << 1;
        if (!CPHA) o_spi_miso <= i_tx_data[DATA_W-1];
      end else if (word_done) begin
        tx_q <= i_tx_data;
      end else if (shift) begin
        o_spi_miso <= tx_q[DATA_W-1];
        tx_q <= tx_q << 1;
      end
    end
`else
  logic unused_tx;
  assign unused_tx = ^i_tx_data;
  assign o_spi_miso = 1'b0;
  assign o_tx_load = 1'b0;
`endif
endmodule

// File: tb/tb_spi_word_receiver.sv
// tb_spi_word_receiver: randomized frames on a 24-bit mode-0 receiver and four 8-bit receivers (modes 0..3)
module tb_spi_word_receiver;
  localparam int HALF = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [4:0] sck = 5'b01100, cs = 5'b11111, mosi = 5'b00000;
  logic [31:0] rxd_w [5];
  logic [7:0] idx_w [5];
  logic [4:0] rv_w, fe_w, err_w, tl_w, miso_w;
  logic [23:0] rx_main;
  logic [23:0] tx24 = 24'h000000;
  logic [7:0] tx8 = 8'h5A;
  int checks = 0, errors = 0;
  logic [31:0] miso_cap;
  spi_word_receiver u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_spi_clk(sck[4]), .i_spi_cs(cs[4]), .i_spi_mosi(mosi[4]),
    .o_spi_miso(miso_w[4]), .i_tx_data(tx24), .o_tx_load(tl_w[4]), .o_rx_data(rx_main),
    .o_rx_valid(rv_w[4]), .o_rx_word_idx(idx_w[4]), .o_frame_end(fe_w[4]), .o_err_short(err_w[4])
  );
  assign rxd_w[4] = {8'h00, rx_main};
  for (genvar g = 0; g < 4; g++) begin : g_mode
    logic [7:0] rx_g;
    spi_word_receiver #(.DATA_W(8), .CPOL(1'(g / 2)), .CPHA(1'(g % 2))) u_dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_spi_clk(sck[g]), .i_spi_cs(cs[g]), .i_spi_mosi(mosi[g]),
      .o_spi_miso(miso_w[g]), .i_tx_data(tx8), .o_tx_load(tl_w[g]), .o_rx_data(rx_g),
      .o_rx_valid(rv_w[g]), .o_rx_word_idx(idx_w[g]), .o_frame_end(fe_w[g]), .o_err_short(err_w[g])
    );
    assign rxd_w[g] = {24'h0, rx_g};
  end
  int cyc = 0;
  int rv_cnt [5] = '{default: 0};
  int fe_cnt [5] = '{default: 0};
  int err_cnt [5] = '{default: 0};
  int tl_cnt [5] = '{default: 0};
  int last_rv [5] = '{default: 0};
  int last_fe [5] = '{default: 0};
  int last_err [5] = '{default: 0};
  logic [31:0] rxd [5][32];
  logic [7:0] rxi [5][32];
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      if (rv_w[k] === 1'b1) begin
        rxd[k][rv_cnt[k] % 32] = rxd_w[k];
        rxi[k][rv_cnt[k] % 32] = idx_w[k];
        rv_cnt[k] = rv_cnt[k] + 1;
        last_rv[k] = cyc;
      end
      if (fe_w[k] === 1'b1) begin fe_cnt[k] = fe_cnt[k] + 1; last_fe[k] = cyc; end
      if (err_w[k] === 1'b1) begin err_cnt[k] = err_cnt[k] + 1; last_err[k] = cyc; end
      if (tl_w[k] === 1'b1) tl_cnt[k] = tl_cnt[k] + 1;
    end
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  // end_mode 0: CS rises after the last bit; 1: CS rises with the last sample edge; 2: CS stays low
  task automatic spi_send(input int inst, input logic [127:0] s, input int n, input int end_mode);
    int m;
    logic cpol, cpha;
    m = inst == 4 ? 0 : inst;
    cpol = m[1];
    cpha = m[0];
    miso_cap = '0;
    cs[inst] = 1'b0;
    wait_clk(HALF);
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi[inst] = s[i];
        wait_clk(HALF);
        miso_cap = {miso_cap[30:0], miso_w[inst]};
        sck[inst] = ~cpol;
        if (end_mode == 1 && i == 0) cs[inst] = 1'b1;
        wait_clk(HALF);
        sck[inst] = cpol;
      end else begin
        sck[inst] = ~cpol;
        mosi[inst] = s[i];
        wait_clk(HALF);
        miso_cap = {miso_cap[30:0], miso_w[inst]};
        sck[inst] = cpol;
        wait_clk(HALF);
      end
    end
    if (end_mode == 0) begin wait_clk(HALF); cs[inst] = 1'b1; end
    if (end_mode != 2) wait_clk(12);
  endtask
  task automatic test_reset;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rxd_w[k] !== 32'h0) begin errors++; $display("FAIL reset_rx_data[%0d]: got %h want 0", k, rxd_w[k]); end
      checks++;
      if (idx_w[k] !== 8'h0) begin errors++; $display("FAIL reset_idx[%0d]: got %h want 0", k, idx_w[k]); end
      checks++;
      if ({rv_w[k], fe_w[k], err_w[k], tl_w[k], miso_w[k]} !== 5'b0) begin
        errors++; $display("FAIL reset_pulses[%0d]: got %b want 00000", k, {rv_w[k], fe_w[k], err_w[k], tl_w[k], miso_w[k]});
      end
    end
  endtask
  task automatic test_single;
    int b_rv, b_fe, b_err;
    logic [23:0] w;
    b_rv = rv_cnt[4]; b_fe = fe_cnt[4]; b_err = err_cnt[4];
    spi_send(4, 128'hA5C33C, 24, 1);
    checks++;
    if (rv_cnt[4] - b_rv !== 1) begin errors++; $display("FAIL single_valid_count: got %0d want 1", rv_cnt[4] - b_rv); end
    checks++;
    if (rxd[4][b_rv % 32] !== 32'hA5C33C) begin errors++; $display("FAIL single_data: got %h want a5c33c", rxd[4][b_rv % 32]); end
    checks++;
    if (rxi[4][b_rv % 32] !== 8'd0) begin errors++; $display("FAIL single_idx: got %0d want 0", rxi[4][b_rv % 32]); end
    checks++;
    if (fe_cnt[4] - b_fe !== 1) begin errors++; $display("FAIL single_frame_end: got %0d want 1", fe_cnt[4] - b_fe); end
    checks++;
    if (err_cnt[4] - b_err !== 0) begin errors++; $display("FAIL single_err: got %0d want 0", err_cnt[4] - b_err); end
    checks++;
    if (last_fe[4] - last_rv[4] < 0 || last_fe[4] - last_rv[4] > 1) begin
      errors++; $display("FAIL single_fe_timing: got %0d cycles after valid want 0..1", last_fe[4] - last_rv[4]);
    end
    w = 24'($urandom);
    b_rv = rv_cnt[4]; b_fe = fe_cnt[4];
    spi_send(4, {104'h0, w}, 24, 0);
    checks++;
    if (rv_cnt[4] - b_rv !== 1 || rxd[4][b_rv % 32] !== {8'h0, w}) begin
      errors++; $display("FAIL single_late_cs: got %0d words data %h want 1 word %h", rv_cnt[4] - b_rv, rxd[4][b_rv % 32], w);
    end
    checks++;
    if (fe_cnt[4] - b_fe !== 1 || last_fe[4] <= last_rv[4]) begin
      errors++; $display("FAIL single_late_fe: got count %0d fe %0d rv %0d want 1 fe after rv", fe_cnt[4] - b_fe, last_fe[4], last_rv[4]);
    end
  endtask
  task automatic test_multi;
    int b_rv, b_fe, b_err;
    logic [23:0] exp_w [3];
    exp_w = '{24'h000001, 24'h800000, 24'hFFFFFF};
    b_rv = rv_cnt[4]; b_fe = fe_cnt[4]; b_err = err_cnt[4];
    spi_send(4, {56'h0, exp_w[0], exp_w[1], exp_w[2]}, 72, 0);
    checks++;
    if (rv_cnt[4] - b_rv !== 3) begin errors++; $display("FAIL multi_valid_count: got %0d want 3", rv_cnt[4] - b_rv); end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (rxd[4][(b_rv + j) % 32] !== {8'h0, exp_w[j]} || rxi[4][(b_rv + j) % 32] !== 8'(j)) begin
        errors++; $display("FAIL multi_word%0d: got %h idx %0d want %h idx %0d", j, rxd[4][(b_rv + j) % 32], rxi[4][(b_rv + j) % 32], exp_w[j], j);
      end
    end
    checks++;
    if (fe_cnt[4] - b_fe !== 1 || err_cnt[4] - b_err !== 0) begin
      errors++; $display("FAIL multi_frame: got fe %0d err %0d want 1 0", fe_cnt[4] - b_fe, err_cnt[4] - b_err);
    end
  endtask
  task automatic test_short;
    int b_rv, b_fe, b_err;
    logic [23:0] w;
    b_rv = rv_cnt[4]; b_fe = fe_cnt[4]; b_err = err_cnt[4];
    spi_send(4, {96'h0, $urandom}, 13, 0);
    checks++;
    if (err_cnt[4] - b_err !== 1 || fe_cnt[4] - b_fe !== 1) begin
      errors++; $display("FAIL short_pulses: got err %0d fe %0d want 1 1", err_cnt[4] - b_err, fe_cnt[4] - b_fe);
    end
    checks++;
    if (last_err[4] !== last_fe[4]) begin errors++; $display("FAIL short_together: got err at %0d fe at %0d want same", last_err[4], last_fe[4]); end
    checks++;
    if (rv_cnt[4] - b_rv !== 0) begin errors++; $display("FAIL short_no_valid: got %0d want 0", rv_cnt[4] - b_rv); end
    w = 24'($urandom);
    b_rv = rv_cnt[4]; b_err = err_cnt[4];
    spi_send(4, {104'h0, w}, 24, 0);
    checks++;
    if (rv_cnt[4] - b_rv !== 1 || rxd[4][b_rv % 32] !== {8'h0, w} || rxi[4][b_rv % 32] !== 8'd0 || err_cnt[4] - b_err !== 0) begin
      errors++; $display("FAIL short_recover: got %0d words %h idx %0d want 1 word %h idx 0", rv_cnt[4] - b_rv, rxd[4][b_rv % 32], rxi[4][b_rv % 32], w);
    end
  endtask
  task automatic test_random;
    int b_rv, b_fe, b_err, n, nw;
    logic [127:0] s;
    logic [23:0] e;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 96);
      s = {$urandom, $urandom, $urandom, $urandom};
      nw = n / 24;
      b_rv = rv_cnt[4]; b_fe = fe_cnt[4]; b_err = err_cnt[4];
      spi_send(4, s, n, 0);
      checks++;
      if (rv_cnt[4] - b_rv !== nw) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d (bits %0d)", it, rv_cnt[4] - b_rv, nw, n); end
      for (int j = 0; j < nw; j++) begin
        e = 24'(s >> (n - 24 * (j + 1)));
        checks++;
        if (rxd[4][(b_rv + j) % 32] !== {8'h0, e} || rxi[4][(b_rv + j) % 32] !== 8'(j)) begin
          errors++; $display("FAIL rand%0d_word%0d: got %h idx %0d want %h idx %0d", it, j, rxd[4][(b_rv + j) % 32], rxi[4][(b_rv + j) % 32], e, j);
        end
      end
      checks++;
      if (fe_cnt[4] - b_fe !== 1 || err_cnt[4] - b_err !== int'(n % 24 != 0)) begin
        errors++; $display("FAIL rand%0d_end: got fe %0d err %0d want 1 %0d", it, fe_cnt[4] - b_fe, err_cnt[4] - b_err, int'(n % 24 != 0));
      end
    end
  endtask
  task automatic test_modes;
    int b_rv, b_err;
    logic [7:0] r;
    for (int m = 0; m < 4; m++) begin
      r = 8'($urandom);
      b_rv = rv_cnt[m]; b_err = err_cnt[m];
      spi_send(m, {112'h0, 8'h96, r}, 16, 0);
      checks++;
      if (rv_cnt[m] - b_rv !== 2 || rxd[m][b_rv % 32] !== 32'h96 || rxi[m][b_rv % 32] !== 8'd0) begin
        errors++; $display("FAIL mode%0d_first: got %0d words %h idx %0d want 2 words 96 idx 0", m, rv_cnt[m] - b_rv, rxd[m][b_rv % 32], rxi[m][b_rv % 32]);
      end
      checks++;
      if (rxd[m][(b_rv + 1) % 32] !== {24'h0, r} || rxi[m][(b_rv + 1) % 32] !== 8'd1 || err_cnt[m] - b_err !== 0) begin
        errors++; $display("FAIL mode%0d_second: got %h idx %0d want %h idx 1", m, rxd[m][(b_rv + 1) % 32], rxi[m][(b_rv + 1) % 32], r);
      end
    end
  endtask
  task automatic test_miso;
    int b_tl;
    logic [7:0] exp_miso;
    int exp_tl;
`ifdef SPI_WORD_RECEIVER_MISO_EN
    exp_miso = 8'h5A; exp_tl = 2;
`else
    exp_miso = 8'h00; exp_tl = 0;
`endif
    for (int m = 0; m < 4; m++) begin
      b_tl = tl_cnt[m];
      spi_send(m, {96'h0, $urandom}, 8, 0);
      checks++;
      if (miso_cap[7:0] !== exp_miso) begin errors++; $display("FAIL miso_mode%0d: got %h want %h", m, miso_cap[7:0], exp_miso); end
      checks++;
      if (tl_cnt[m] - b_tl !== exp_tl) begin errors++; $display("FAIL tx_load_mode%0d: got %0d want %0d", m, tl_cnt[m] - b_tl, exp_tl); end
    end
  endtask
  task automatic test_reset_mid;
    int b_rv, b_fe, b_err;
    logic [23:0] w;
    b_rv = rv_cnt[4]; b_fe = fe_cnt[4]; b_err = err_cnt[4];
    spi_send(4, {96'h0, $urandom}, 10, 2);
    wait_clk(HALF);
    rst_n = 1'b0;
    wait_clk(2);
    checks++;
    if (rx_main !== 24'h0 || idx_w[4] !== 8'h0) begin errors++; $display("FAIL rstmid_regs: got %h idx %0d want 0 0", rx_main, idx_w[4]); end
    checks++;
    if ({rv_w[4], fe_w[4], err_w[4], tl_w[4], miso_w[4]} !== 5'b0) begin
      errors++; $display("FAIL rstmid_pulses: got %b want 00000", {rv_w[4], fe_w[4], err_w[4], tl_w[4], miso_w[4]});
    end
    rst_n = 1'b1;
    wait_clk(20);
    cs[4] = 1'b1;
    wait_clk(20);
    checks++;
    if (rv_cnt[4] - b_rv !== 0 || fe_cnt[4] - b_fe !== 0 || err_cnt[4] - b_err !== 0) begin
      errors++; $display("FAIL rstmid_silent: got rv %0d fe %0d err %0d want 0 0 0", rv_cnt[4] - b_rv, fe_cnt[4] - b_fe, err_cnt[4] - b_err);
    end
    w = 24'($urandom);
    b_rv = rv_cnt[4];
    spi_send(4, {104'h0, w}, 24, 0);
    checks++;
    if (rv_cnt[4] - b_rv !== 1 || rxd[4][b_rv % 32] !== {8'h0, w} || rxi[4][b_rv % 32] !== 8'd0) begin
      errors++; $display("FAIL rstmid_after: got %0d words %h idx %0d want 1 word %h idx 0", rv_cnt[4] - b_rv, rxd[4][b_rv % 32], rxi[4][b_rv % 32], w);
    end
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    wait_clk(3);
    test_reset;
    rst_n = 1'b1;
    wait_clk(12);
    test_single;
    test_multi;
    test_short;
    test_random;
    test_modes;
    test_miso;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_word_receiver.md
SPI_WORD_RECEIVER -- requirements
Module: spi_word_receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 24, bits per word (8..32).
REQ-002 SHALL have parameter CPOL, default 0, SCK idle level.
REQ-003 SHALL have parameter CPHA, default 0. 0 means sample on the leading edge; 1 means sample on the trailing edge.
REQ-004 SHALL have parameter SYNC_STAGES, default 3, synchronizer depth (2..4).
REQ-005 SHALL have port i_clk, input, 1 bit, sole clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-007 SHALL have port i_spi_clk, input, 1 bit, raw SCK (asynchronous).
REQ-008 SHALL have port i_spi_cs, input, 1 bit, raw chip select, active-low.
REQ-009 SHALL have port i_spi_mosi, input, 1 bit, raw MOSI.
REQ-010 SHALL have port o_spi_miso, output, 1 bit, MISO data.
REQ-011 SHALL have port i_tx_data, input, DATA_W bits, next word to transmit.
REQ-012 SHALL have port o_tx_load, output, 1 bit, pulse when i_tx_data is captured.
REQ-013 SHALL have port o_rx_data, output, DATA_W bits, last complete received word.
REQ-014 SHALL have port o_rx_valid, output, 1 bit, one-cycle pulse when o_rx_data updates.
REQ-015 SHALL have port o_rx_word_idx, output, 8 bits, index of the o_rx_data word within the frame.
REQ-016 SHALL have port o_frame_end, output, 1 bit, one-cycle pulse on CS deassertion.
REQ-017 SHALL have port o_err_short, output, 1 bit, one-cycle pulse when a frame ends mid-word.

Function
REQ-018 SHALL pass SCK, CS and MOSI through SYNC_STAGES flops each, then detect edges on the synchronized outputs. No logic shall be clocked by i_spi_clk.
REQ-019 SHALL operate correctly with i_clk at or above 8x the SCK frequency; behaviour below that ratio is undefined.
REQ-020 SHALL define the sample edge as: rising if CPOL==CPHA, falling otherwise. The opposite SCK edge is the shift edge.
REQ-021 SHALL ignore SCK edges while synchronized CS is high.
REQ-022 SHALL shift MOSI in MSB first on each sample edge and increment a bit counter running 0..DATA_W-1.
REQ-023 SHALL, on the DATA_W-th sample edge, load o_rx_data and pulse o_rx_valid on the next cycle, then clear the bit counter. Latency is 1 i_clk cycle after edge detection.
REQ-024 SHALL set o_rx_word_idx to 0 for the first word of a frame, increment it per word, and saturate at 255.
REQ-025 SHALL, on a CS rising edge, pulse o_frame_end and clear the bit counter, word index and shift register.
REQ-026 SHALL additionally pulse o_err_short with o_frame_end if the bit counter is nonzero; the partial word is discarded and o_rx_valid is not asserted for it.
REQ-027 SHALL, if the final sample edge and the CS rising edge are detected in the same cycle, complete the word first. o_rx_valid and o_frame_end then pulse together and o_err_short does not pulse.
REQ-028 SHALL, on a CS falling edge, start a new frame. A CS glitch shorter than SYNC_STAGES cycles may be missed and SHALL NOT corrupt state.

Reset
REQ-029 SHALL reset asynchronously on i_rst_n low, with release synchronous to i_clk.
REQ-030 SHALL reset values as follows:
- SCK synchronizer to CPOL, CS synchronizer to 1, MOSI synchronizer to 0
- o_rx_data, o_rx_word_idx and the shift register to 0
- all pulse outputs to 0
- o_spi_miso to 0
REQ-031 SHALL, on reset mid-frame, discard the frame without pulses and wait for the next CS falling edge.

Configuration
REQ-032 SHALL compile the MISO transmit path only when SPI_WORD_RECEIVER_MISO_EN is defined.
REQ-033 SHALL, with SPI_WORD_RECEIVER_MISO_EN defined:
- capture i_tx_data and pulse o_tx_load on CS fall and on each word completion
- drive the MSB on o_spi_miso immediately when CPHA=0
- advance o_spi_miso MSB first on each shift edge
REQ-034 SHALL, without SPI_WORD_RECEIVER_MISO_EN, tie o_spi_miso and o_tx_load to 0 and ignore i_tx_data. Port list is identical in both builds.

Structure
REQ-035 SHALL place the SPI mode constants (CPOL/CPHA pairs), the default DATA_W and the word-index width in shared package spi_pkg.
REQ-036 SHALL implement the synchronizer and edge detector as sub-module spi_edge_sync (parameter SYNC_STAGES, reset value; outputs level, rise, fall), instantiated for SCK and CS.

Verification
REQ-037 SHALL cover default config: one 24-bit frame 0xA5C33C -> o_rx_valid once, o_rx_data=0xA5C33C, idx=0, o_frame_end one cycle after the last valid or together with it, no error.
REQ-038 SHALL cover three words 0x000001, 0x800000, 0xFFFFFF in one CS frame -> three o_rx_valid pulses, idx 0,1,2, one o_frame_end.
REQ-039 SHALL cover CS raised after 13 bits -> o_err_short and o_frame_end pulse together, no o_rx_valid; the next full frame is received correctly.
REQ-040 SHALL cover each mode 0..3 with DATA_W=8 and byte 0x96 -> o_rx_data=0x96 in all four modes.
REQ-041 SHALL cover MISO_EN build with i_tx_data=0x5A, DATA_W=8, mode 0 -> MISO bits 0,1,0,1,1,0,1,0 observed on sample edges; one o_tx_load at CS fall and one after the word.
REQ-042 SHALL cover i_rst_n asserted at bit 10 of a word -> all outputs reach reset values; the frame after reset returns the correct word with idx=0.
